// File: rtl/maze_pkg.sv
// Shared types for maze actors: direction codes, tile classes and FSM states.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [1:0] WALL = 2'b00;
  localparam logic [1:0] WKNP = 2'b01;
  localparam logic [1:0] WKRP = 2'b10;
  localparam logic [1:0] WKGH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_DEAD  = 2'b11
  } actor_state_t;

  // Encoding makes the opposite direction a plain bit inversion.
  function automatic dir_t reverse(dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/maze_actor_if.sv
// Command, maze-neighbourhood and position bus between AI/input logic and an actor.
interface maze_actor_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int TW = 7
);
  logic            cmd_valid;
  logic [1:0]      cmd_dir;
  logic [3:0][1:0] tile_info;
  logic            pellet_here;
  logic [XW-1:0]   xloc;
  logic [YW-1:0]   yloc;
  logic [1:0]      dir;
  logic [TW-1:0]   xtile;
  logic [TW-1:0]   ytile;
  logic            moving;
  logic            tile_enter;
  logic            eat;
  logic [1:0]      state;

  modport master (
    output cmd_valid, cmd_dir, tile_info, pellet_here,
    input  xloc, yloc, dir, xtile, ytile, moving, tile_enter, eat, state
  );

  modport slave (
    input  cmd_valid, cmd_dir, tile_info, pellet_here,
    output xloc, yloc, dir, xtile, ytile, moving, tile_enter, eat, state
  );
endinterface

// File: rtl/maze_actor_frac_stepper.sv
// Fractional speed accumulator: emits a step whenever acc+num reaches den.
module frac_stepper #(
  parameter int SPW = 8
) (
  input  logic           clk60,
  input  logic           reset,
  input  logic           advance,
  input  logic [SPW-1:0] speed_num,
  input  logic [SPW-1:0] speed_den,
  output logic           step
);
  // One extra bit so the sum never overflows; acc itself stays below den.
  logic [SPW:0] acc_reg;
  logic [SPW:0] acc_next;
  logic [SPW:0] sum;

  always_comb begin
    sum      = acc_reg + {1'b0, speed_num};
    step     = (sum >= {1'b0, speed_den});
    acc_next = acc_reg;
    if (advance) begin
      acc_next = step ? (sum - {1'b0, speed_den}) : sum;
    end
  end

  always_ff @(posedge clk60) begin
    if (reset) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end
endmodule

// File: rtl/maze_actor.sv
// Per-frame actor position engine: queued turns, fractional speed, tunnel wrap, eat stalls.
module maze_actor
  import maze_pkg::*;
#(
  parameter int         XW          = 10,
  parameter int         YW          = 10,
  parameter int         TW          = 7,
  parameter int         TILE_PX     = 8,
  parameter int         CENTER      = 3,
  parameter int         Y_TILE_OFS  = 3,
  parameter int         MAZE_PX_W   = 224,
  parameter int         START_X     = 119,
  parameter int         START_Y     = 227,
  parameter logic [1:0] START_DIR   = 2'b00,
  parameter int         SPW         = 8,
  parameter int         EAT_STALL   = 1,
  parameter int         GH_WALKABLE = 0
) (
  input  logic           clk60,
  input  logic           reset,
  input  logic           start,
  input  logic           kill,
  input  logic           freeze,
  input  logic [SPW-1:0] speed_num,
  input  logic [SPW-1:0] speed_den,
  maze_actor_if.slave    bus
);
  localparam int PXB = $clog2(TILE_PX);
  localparam int SCW = (EAT_STALL > 1) ? $clog2(EAT_STALL) : 1;
  localparam logic [PXB-1:0] CENTER_L = PXB'(CENTER);

  actor_state_t  state_reg, state_next;
  logic [XW-1:0] x_reg, x_next, x_mv;
  logic [YW-1:0] y_reg, y_next, y_mv;
  dir_t          dir_reg, dir_next, queue_reg, queue_next, dir_d;
  logic [SCW-1:0] stall_reg, stall_next;
  logic          moving_reg, moving_next;
  logic          tile_enter_reg, tile_enter_next;
  logic          eat_reg, eat_next;
  logic          advance, step, at_center, blocked, mv_center;

  function automatic logic legal(logic [1:0] cls);
    return (cls != WALL) && ((GH_WALKABLE != 0) || (cls != WKGH));
  endfunction

  frac_stepper #(.SPW(SPW)) u_stepper (
    .clk60     (clk60),
    .reset     (reset),
    .advance   (advance),
    .speed_num (speed_num),
    .speed_den (speed_den),
    .step      (step)
  );

  assign at_center = (x_reg[PXB-1:0] == CENTER_L) && (y_reg[PXB-1:0] == CENTER_L);

  // Direction choice and the candidate one-pixel move along it.
  always_comb begin
    dir_d = dir_reg;
    if (queue_reg == reverse(dir_reg)) begin
      dir_d = queue_reg;
    end else if (at_center && legal(bus.tile_info[queue_reg])) begin
      dir_d = queue_reg;
    end
    blocked = at_center && !legal(bus.tile_info[dir_d]);

    x_mv = x_reg;
    y_mv = y_reg;
    case (dir_d)
      DIR_RIGHT: x_mv = (x_reg == XW'(MAZE_PX_W - 1)) ? '0 : x_reg + XW'(1);
      DIR_LEFT:  x_mv = (x_reg == '0) ? XW'(MAZE_PX_W - 1) : x_reg - XW'(1);
      DIR_UP:    y_mv = y_reg - YW'(1);
      DIR_DOWN:  y_mv = y_reg + YW'(1);
    endcase
    mv_center = (x_mv[PXB-1:0] == CENTER_L) && (y_mv[PXB-1:0] == CENTER_L);
  end

  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    dir_next        = dir_reg;
    stall_next      = stall_reg;
    moving_next     = 1'b0;
    tile_enter_next = 1'b0;
    eat_next        = 1'b0;
    advance         = 1'b0;
    // The queue keeps listening even while frozen, idle or dead.
    queue_next      = bus.cmd_valid ? dir_t'(bus.cmd_dir) : queue_reg;

    if (kill && (state_reg == ST_RUN || state_reg == ST_STALL)) begin
      state_next = ST_DEAD;
    end else if (!freeze) begin
      case (state_reg)
        ST_IDLE: begin
          if (start) state_next = ST_RUN;
        end
        ST_RUN: begin
          advance  = 1'b1;
          dir_next = dir_d;
          if (step && !blocked) begin
            x_next          = x_mv;
            y_next          = y_mv;
            moving_next     = 1'b1;
            tile_enter_next = mv_center;
            eat_next        = mv_center && bus.pellet_here;
            if (mv_center && bus.pellet_here && (EAT_STALL > 0)) begin
              state_next = ST_STALL;
              stall_next = '0;
            end
          end
        end
        ST_STALL: begin
          if (stall_reg == SCW'(EAT_STALL - 1)) begin
            state_next = ST_RUN;
            stall_next = '0;
          end else begin
            stall_next = stall_reg + SCW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk60) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      x_reg          <= XW'(START_X);
      y_reg          <= YW'(START_Y);
      dir_reg        <= dir_t'(START_DIR);
      queue_reg      <= dir_t'(START_DIR);
      stall_reg      <= '0;
      moving_reg     <= 1'b0;
      tile_enter_reg <= 1'b0;
      eat_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      dir_reg        <= dir_next;
      queue_reg      <= queue_next;
      stall_reg      <= stall_next;
      moving_reg     <= moving_next;
      tile_enter_reg <= tile_enter_next;
      eat_reg        <= eat_next;
    end
  end

  assign bus.xloc       = x_reg;
  assign bus.yloc       = y_reg;
  assign bus.dir        = dir_reg;
  assign bus.state      = state_reg;
  assign bus.moving     = moving_reg;
  assign bus.tile_enter = tile_enter_reg;
  assign bus.eat        = eat_reg;
  assign bus.xtile      = TW'(x_reg >> PXB);
  assign bus.ytile      = TW'((y_reg >> PXB) - YW'(Y_TILE_OFS));
endmodule

// File: tb/tb_maze_actor.sv
// Scenario bench for maze_actor: expected frames are queued as stimulus is driven.
module tb_maze_actor;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_DEAD = 2'd3;
  localparam logic [1:0] R = 2'd0, U = 2'd1, L = 2'd3;
  localparam logic [7:0] ALL_OPEN = 8'h55;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] d;
    logic [9:0] x;
    logic [9:0] y;
    logic       mv;
    logic       te;
    logic       ea;
  } snap_t;

  logic       clk60 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       kill = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] speed_num = 8'd1;
  logic [7:0] speed_den = 8'd1;
  snap_t      exp_q[$];
  int         total = 0;
  int         bad = 0;

  maze_actor_if bus ();

  maze_actor dut (
    .clk60     (clk60),
    .reset     (reset),
    .start     (start),
    .kill      (kill),
    .freeze    (freeze),
    .speed_num (speed_num),
    .speed_den (speed_den),
    .bus       (bus)
  );

  always #5 clk60 = ~clk60;

  task automatic tick();
    @(posedge clk60);
    #1;
  endtask

  function automatic snap_t snap();
    snap_t s;
    s = {bus.state, bus.dir, bus.xloc, bus.yloc, bus.moving, bus.tile_enter, bus.eat};
    return s;
  endfunction

  function automatic snap_t mk(logic [1:0] st, logic [1:0] d, int x, int y,
                               logic mv, logic te, logic ea);
    snap_t s;
    s.st = st; s.d = d; s.x = 10'(x); s.y = 10'(y);
    s.mv = mv; s.te = te; s.ea = ea;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d dir=%0d x=%0d y=%0d mv=%0b te=%0b eat=%0b",
                     s.st, s.d, s.x, s.y, s.mv, s.te, s.ea);
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; kill = 1'b0; freeze = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dir = R; bus.tile_info = ALL_OPEN; bus.pellet_here = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got, want;
    do_reset();
    exp_q.push_back(mk(S_IDLE, R, 119, 227, 0, 0, 0));
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_state: got %s want %s", fmt(got), fmt(want)); end
    else $display("reset_state: %s", fmt(got));
    total++;
    if (bus.xtile !== 7'd14 || bus.ytile !== 7'd25) begin
      bad++; $display("FAIL reset_tiles: got xt=%0d yt=%0d want xt=14 yt=25", bus.xtile, bus.ytile);
    end else $display("reset_tiles: xt=%0d yt=%0d", bus.xtile, bus.ytile);
    kill = 1'b1;
    exp_q.push_back(mk(S_IDLE, R, 119, 227, 0, 0, 0));
    tick();
    kill = 1'b0;
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL idle_kill: got %s want %s", fmt(got), fmt(want)); end
    else $display("idle_kill: %s", fmt(got));
  endtask

  task automatic test_run();
    snap_t got, want;
    speed_num = 8'd1; speed_den = 8'd1;
    start = 1'b1;
    exp_q.push_back(mk(S_RUN, R, 119, 227, 0, 0, 0));
    tick();
    start = 1'b0;
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL run_start: got %s want %s", fmt(got), fmt(want)); end
    else $display("run_start: %s", fmt(got));
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(S_RUN, R, 119 + i, 227, 1, i == 4, 0));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL run f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("run f%0d: %s", i, fmt(got));
    end
  endtask

  task automatic test_wall();
    snap_t got, want;
    bus.tile_info = ALL_OPEN;
    bus.tile_info[R] = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk(S_RUN, R, 123, 227, 0, 0, 0));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wall f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("wall f%0d: %s", i, fmt(got));
    end
    bus.tile_info = ALL_OPEN;
  endtask

  task automatic test_turn();
    snap_t got, want;
    do_reset();
    launch();
    tick(); tick();
    bus.cmd_valid = 1'b1; bus.cmd_dir = U;
    exp_q.push_back(mk(S_RUN, R, 122, 227, 1, 0, 0));
    tick();
    bus.cmd_valid = 1'b0;
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL turn_cmd: got %s want %s", fmt(got), fmt(want)); end
    else $display("turn_cmd: %s", fmt(got));
    exp_q.push_back(mk(S_RUN, R, 123, 227, 1, 1, 0));
    tick();
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL turn_center: got %s want %s", fmt(got), fmt(want)); end
    else $display("turn_center: %s", fmt(got));
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(S_RUN, U, 123, 227 - k, 1, 0, 0));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL turn_up f%0d: got %s want %s", k, fmt(got), fmt(want)); end
      else $display("turn_up f%0d: %s", k, fmt(got));
    end
  endtask

  task automatic test_reverse();
    snap_t got, want;
    do_reset();
    launch();
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_dir = L;
    exp_q.push_back(mk(S_RUN, R, 121, 227, 1, 0, 0));
    tick();
    bus.cmd_valid = 1'b0;
    exp_q.push_back(mk(S_RUN, L, 120, 227, 1, 0, 0));
    exp_q.push_back(mk(S_RUN, L, 119, 227, 1, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reverse f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("reverse f%0d: %s", i, fmt(got));
    end
  endtask

  task automatic test_speed_freeze();
    snap_t got, want;
    int    x;
    logic  mv;
    do_reset();
    speed_num = 8'd4; speed_den = 8'd5;
    launch();
    x = 119;
    for (int i = 1; i <= 10; i++) begin
      mv = !(i == 1 || i == 6);
      if (mv) x++;
      exp_q.push_back(mk(S_RUN, R, x, 227, mv, mv && (x == 123), 0));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL speed f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("speed f%0d: %s", i, fmt(got));
    end
    freeze = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_dir = L;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(mk(S_RUN, R, 127, 227, 0, 0, 0));
      tick();
      bus.cmd_valid = 1'b0;
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL freeze f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("freeze f%0d: %s", i, fmt(got));
    end
    freeze = 1'b0;
    exp_q.push_back(mk(S_RUN, L, 127, 227, 0, 0, 0));
    exp_q.push_back(mk(S_RUN, L, 126, 227, 1, 0, 0));
    for (int i = 1; i <= 2; i++) begin
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL unfreeze f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("unfreeze f%0d: %s", i, fmt(got));
    end
    freeze = 1'b1; kill = 1'b1;
    exp_q.push_back(mk(S_DEAD, L, 126, 227, 0, 0, 0));
    tick();
    freeze = 1'b0; kill = 1'b0; start = 1'b1;
    exp_q.push_back(mk(S_DEAD, L, 126, 227, 0, 0, 0));
    for (int i = 1; i <= 2; i++) begin
      if (i > 1) tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL kill_freeze f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("kill_freeze f%0d: %s", i, fmt(got));
    end
    start = 1'b0;
    speed_num = 8'd1; speed_den = 8'd1;
  endtask

  task automatic test_tunnel_eat_kill();
    snap_t got, want;
    int    x;
    logic  ctr;
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_dir = L;
    launch();
    bus.cmd_valid = 1'b0;
    // Walk left from 119 to 0, then wrap to 223 and on to the 219 centre.
    for (int i = 1; i <= 124; i++) begin
      x = (i <= 119) ? (119 - i) : (223 - (i - 120));
      ctr = ((x % 8) == 3);
      bus.pellet_here = (i > 120);
      exp_q.push_back(mk((x == 219) ? S_STALL : S_RUN, L, x, 227, 1, ctr, ctr && (i > 120)));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL tunnel f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("tunnel f%0d: %s", i, fmt(got));
    end
    exp_q.push_back(mk(S_RUN, L, 219, 227, 0, 0, 0));
    tick();
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL stall_frame: got %s want %s", fmt(got), fmt(want)); end
    else $display("stall_frame: %s", fmt(got));
    for (int i = 1; i <= 8; i++) begin
      x = 219 - i;
      exp_q.push_back(mk((x == 211) ? S_STALL : S_RUN, L, x, 227, 1, x == 211, x == 211));
      tick();
      got = snap(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL second_eat f%0d: got %s want %s", i, fmt(got), fmt(want)); end
      else $display("second_eat f%0d: %s", i, fmt(got));
    end
    kill = 1'b1;
    exp_q.push_back(mk(S_DEAD, L, 211, 227, 0, 0, 0));
    tick();
    kill = 1'b0;
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL stall_kill: got %s want %s", fmt(got), fmt(want)); end
    else $display("stall_kill: %s", fmt(got));
    exp_q.push_back(mk(S_DEAD, L, 211, 227, 0, 0, 0));
    tick();
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL dead_hold: got %s want %s", fmt(got), fmt(want)); end
    else $display("dead_hold: %s", fmt(got));
    reset = 1'b1;
    exp_q.push_back(mk(S_IDLE, R, 119, 227, 0, 0, 0));
    tick();
    reset = 1'b0;
    bus.pellet_here = 1'b0;
    got = snap(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL dead_reset: got %s want %s", fmt(got), fmt(want)); end
    else $display("dead_reset: %s", fmt(got));
  endtask

  initial begin
    test_reset();
    test_run();
    test_wall();
    test_turn();
    test_reverse();
    test_speed_freeze();
    test_tunnel_eat_kill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
